// File: rtl/ebuf_rx.sv
// rtl/ebuf_rx.sv - wide-word FIFO that streams each entry out as LSB-first narrow slices
module ebuf_rx #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_valid,
    input  logic [IN_W-1:0]            in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       ovf,
    input  logic                       clr_ovf
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int CW    = $clog2(RATIO);

    logic [IN_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   slice;
    logic [IN_W-1:0] head;
    logic            push;
    logic            pop;
    logic            slice_xfer;
    logic            ovf_set;

    // Handshake signals depend only on registered state, never on out_ready.
    assign in_ready   = (level < LW'(DEPTH));
    assign out_valid  = (level != '0);
    assign out_last   = out_valid && (slice == CW'(RATIO - 1));
    assign push       = in_valid && in_ready;
    assign ovf_set    = in_valid && !in_ready;
    assign slice_xfer = out_valid && out_ready;
    assign pop        = slice_xfer && out_last;
    assign head       = mem[rd_ptr];

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int k = 0; k < RATIO; k++) begin
                if (slice == CW'(k)) begin
                    out_data = head[k*OUT_W +: OUT_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            slice  <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (slice_xfer) begin
                if (out_last) begin
                    slice  <= '0;
                    rd_ptr <= rd_ptr + AW'(1);
                end else begin
                    slice <= slice + CW'(1);
                end
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // A new overflow in the same cycle as a clear keeps the flag set.
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ebuf_rx.sv
// tb/tb_ebuf_rx.sv - directed self-checking bench for ebuf_rx
`timescale 1ns/1ps
module tb_ebuf_rx;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic [2:0]  level;
    logic        ovf;
    logic        clr_ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ebuf_rx #(.IN_W(32), .OUT_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .level     (level),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        step(); step();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got %b exp 0", out_last); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", level); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [31:0] w;
        w = 32'h44332211;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = w;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_no_bypass got %b exp 0", out_valid); end
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d] got %b exp 1", k, out_valid); end
            n_cmp++; if (out_data !== w[k*8 +: 8]) begin n_err++; $display("FAIL basic_data[%0d] got %h exp %h", k, out_data, w[k*8 +: 8]); end
            n_cmp++; if (out_last !== (k == 3)) begin n_err++; $display("FAIL basic_last[%0d] got %b exp %b", k, out_last, (k == 3)); end
            step();
        end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL basic_level_end got %0d exp 0", level); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_end got %b exp 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL basic_data_end got %h exp 00", out_data); end
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hDDCCBBAA;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_data !== 8'hAA) begin n_err++; $display("FAIL stall_first got %h exp aa", out_data); end
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_data !== 8'hBB) begin n_err++; $display("FAIL stall_hold_data[%0d] got %h exp bb", i, out_data); end
            n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL stall_hold_last[%0d] got %b exp 0", i, out_last); end
            step();
        end
        n_cmp++; if (out_data !== 8'hBB) begin n_err++; $display("FAIL stall_resume_bb got %h exp bb", out_data); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_data !== 8'hCC) begin n_err++; $display("FAIL stall_cc got %h exp cc", out_data); end
        step();
        n_cmp++; if (out_data !== 8'hDD) begin n_err++; $display("FAIL stall_dd got %h exp dd", out_data); end
        n_cmp++; if (out_last !== 1'b1) begin n_err++; $display("FAIL stall_dd_last got %b exp 1", out_last); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            step();
        end
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL ovf_full_level got %0d exp 4", level); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ovf_full_ready got %b exp 0", in_ready); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_before got %b exp 0", ovf); end
        in_data = 32'h5;
        step();
        in_valid = 1'b0;
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL ovf_level got %0d exp 4", level); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ovf_ready got %b exp 0", in_ready); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", ovf); end
        step();
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
    endtask

    task automatic test_ovf_clear();
        clr_ovf = 1'b1; in_valid = 1'b1; in_data = 32'h6;
        step();
        in_valid = 1'b0;
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL clr_set_wins got %b exp 1", ovf); end
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL clr_level got %0d exp 4", level); end
        step();
        clr_ovf = 1'b0;
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL clr_alone got %b exp 0", ovf); end
    endtask

    task automatic test_drain();
        logic [7:0] e;
        out_ready = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            for (int k = 0; k < 4; k++) begin
                e = (k == 0) ? 8'(w) : 8'h00;
                n_cmp++; if (out_valid !== 1'b1 || out_data !== e) begin n_err++; $display("FAIL drain_w%0d_s%0d got %b/%h exp 1/%h", w, k, out_valid, out_data, e); end
                n_cmp++; if (out_last !== (k == 3)) begin n_err++; $display("FAIL drain_last_w%0d_s%0d got %b exp %b", w, k, out_last, (k == 3)); end
                step();
            end
        end
        n_cmp++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL drain_end got level %0d valid %b exp 0/0", level, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        words[0] = 32'h13121110; words[1] = 32'h23222120; words[2] = 32'h33323130;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = words[i];
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL b2b_level_pre got %0d exp 2", level); end
        out_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (out_data !== words[w][k*8 +: 8]) begin n_err++; $display("FAIL b2b_w%0d_s%0d got %h exp %h", w, k, out_data, words[w][k*8 +: 8]); end
                if (w == 0 && k == 3) begin
                    n_cmp++; if (out_last !== 1'b1) begin n_err++; $display("FAIL b2b_last got %b exp 1", out_last); end
                    in_valid = 1'b1; in_data = words[2];
                end
                step();
                in_valid = 1'b0;
                if (w == 0 && k == 3) begin
                    n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL b2b_level_hold got %0d exp 2", level); end
                end
            end
        end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL b2b_level_end got %0d exp 0", level); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h44332211;
        step();
        in_valid = 1'b0;
        step(); step();
        n_cmp++; if (out_data !== 8'h33) begin n_err++; $display("FAIL rst_mid_pre got %h exp 33", out_data); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin n_err++; $display("FAIL rst_async_out got %b/%h/%b exp 0/00/0", out_valid, out_data, out_last); end
        n_cmp++; if (level !== 3'd0 || in_ready !== 1'b1 || ovf !== 1'b0) begin n_err++; $display("FAIL rst_async_state got %0d/%b/%b exp 0/1/0", level, in_ready, ovf); end
        step();
        resetn = 1'b1;
        step();
        w = 32'h88776655;
        in_valid = 1'b1; in_data = w;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_data !== w[k*8 +: 8]) begin n_err++; $display("FAIL rst_after_s%0d got %h exp %h", k, out_data, w[k*8 +: 8]); end
            step();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_after_end got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_ovf_clear();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
